// File: rtl/spi_host.sv
// spi_host: SPI mode-0 master on the RISC5 I/O bus.
// A data write starts one full-duplex transfer, MSB first: 8 bits in slow
// mode or 32 bits in fast mode. A control write sets the slave selects and
// the mode for the next transfer.
// Optional feature macro: SPI_HOST_IRQ_EN adds a level transfer-done
// interrupt. A data read or an accepted data write clears it.
module spi_host #(
   parameter int SLOW_DIV = 32,
   parameter int FAST_DIV = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_en,
   input  logic        ctrl_en,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic [31:0] status,
   output logic [1:0]  ss_n,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso
`ifdef SPI_HOST_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam logic [5:0] SLOW_CNT = 6'(SLOW_DIV - 1);
   localparam logic [5:0] FAST_CNT = 6'(FAST_DIV - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   state_t      state, state_next;
   logic [5:0]  cnt, cnt_next;
   logic [5:0]  nb, nb_next;
   logic [31:0] tx, tx_next;
   logic [31:0] rx, rx_next;
   logic [31:0] dout_next;
   logic        sclk_next, mosi_next;
   logic        ready, ready_next;
   logic        fast;
   logic        xfast, xfast_next;
   logic        accept;
   logic        done;

   assign status = {31'b0, ready};

   // Next-state and datapath updates of the shift engine.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      nb_next    = nb;
      tx_next    = tx;
      rx_next    = rx;
      dout_next  = dout;
      sclk_next  = sclk;
      mosi_next  = mosi;
      ready_next = ready;
      xfast_next = xfast;
      accept     = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (data_en && wr) begin
               accept     = 1'b1;
               state_next = LOW;
               ready_next = 1'b0;
               xfast_next = fast;
               if (fast) begin
                  cnt_next  = FAST_CNT;
                  nb_next   = 6'd31;
                  tx_next   = din;
                  mosi_next = din[31];
               end else begin
                  cnt_next  = SLOW_CNT;
                  nb_next   = 6'd7;
                  tx_next   = {din[7:0], 24'b0};
                  mosi_next = din[7];
               end
            end
         end
         LOW: begin
            if (cnt == 6'd0) begin
               state_next = HIGH;
               sclk_next  = 1'b1;
               rx_next    = {rx[30:0], miso};
               cnt_next   = xfast ? FAST_CNT : SLOW_CNT;
            end else begin
               cnt_next = cnt - 6'd1;
            end
         end
         HIGH: begin
            if (cnt == 6'd0) begin
               sclk_next = 1'b0;
               if (nb != 6'd0) begin
                  state_next = LOW;
                  tx_next    = {tx[30:0], 1'b0};
                  mosi_next  = tx[30];
                  nb_next    = nb - 6'd1;
                  cnt_next   = xfast ? FAST_CNT : SLOW_CNT;
               end else begin
                  state_next = IDLE;
                  mosi_next  = 1'b1;
                  ready_next = 1'b1;
                  done       = 1'b1;
                  dout_next  = xfast ? rx : {24'b0, rx[7:0]};
               end
            end else begin
               cnt_next = cnt - 6'd1;
            end
         end
         default: begin
            state_next = IDLE;
            sclk_next  = 1'b0;
            mosi_next  = 1'b1;
            ready_next = 1'b1;
         end
      endcase
   end

   // Shift engine registers; reset aborts any transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 6'd0;
         nb    <= 6'd0;
         tx    <= 32'b0;
         rx    <= 32'b0;
         dout  <= 32'b0;
         sclk  <= 1'b0;
         mosi  <= 1'b1;
         ready <= 1'b1;
         xfast <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         nb    <= nb_next;
         tx    <= tx_next;
         rx    <= rx_next;
         dout  <= dout_next;
         sclk  <= sclk_next;
         mosi  <= mosi_next;
         ready <= ready_next;
         xfast <= xfast_next;
      end
   end

   // Control register: slave selects and mode, writable even while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_n <= 2'b11;
         fast <= 1'b0;
      end else if (ctrl_en && wr) begin
         ss_n <= ~din[1:0];
         fast <= din[2];
      end
   end

`ifdef SPI_HOST_IRQ_EN
   // Transfer-done interrupt; a completion in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq <= 1'b0;
      end else if (done) begin
         irq <= 1'b1;
      end else if ((data_en && rd) || accept) begin
         irq <= 1'b0;
      end
   end
`else
   logic unused_rd;
   assign unused_rd = rd;
`endif

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: self-checking bench for spi_host. A bit-level slave model
// feeds miso, and a monitor records sclk rises. The expectations come from
// the transfer rules: bit count, MSB-first order and DIV-based timing.
module tb_spi_host;

   localparam int SLOW_DIV = 32;
   localparam int FAST_DIV = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_en, ctrl_en, rd, wr;
   logic [31:0] din;
   logic [31:0] dout, status;
   logic [1:0]  ss_n;
   logic        sclk, mosi, miso;
`ifdef SPI_HOST_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model state.
   bit          model_fast;
   int          exp_n, exp_div, we;
   logic [31:0] exp_tx, exp_rx, sword;
   int          slen, sidx;
   int          rise_q[$];
   bit          mosi_q[$];

   spi_host #(.SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .data_en(data_en), .ctrl_en(ctrl_en),
      .rd(rd), .wr(wr), .din(din), .dout(dout), .status(status),
      .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso)
`ifdef SPI_HOST_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge k it holds k.
   always @(posedge clk) cyc++;

   // Slave: presents the next bit after every falling sclk.
   always @(negedge sclk) begin
      sidx++;
      if (sidx < slen) miso = sword[slen-1-sidx];
   end

   // Monitor: timestamp of every rise and the mosi bit sampled there.
   always @(posedge sclk) begin
      rise_q.push_back(cyc);
      mosi_q.push_back(mosi);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one bus write at the next posedge; ends at the following negedge.
   task automatic bus_write(input bit is_data, input logic [31:0] v, output int edge_no);
      data_en = is_data;
      ctrl_en = !is_data;
      wr      = 1'b1;
      din     = v;
      @(posedge clk);
      #1 edge_no = cyc;
      @(negedge clk);
      data_en = 1'b0;
      ctrl_en = 1'b0;
      wr      = 1'b0;
   endtask

   task automatic ctrl_write(input logic [31:0] v);
      int e;
      bus_write(1'b0, v, e);
      model_fast = v[2];
      check("ctrl_ss_n", {30'b0, ss_n}, {30'b0, ~v[1:0]});
   endtask

   task automatic start_xfer(input logic [31:0] data, input logic [31:0] slave);
      exp_n   = model_fast ? 32 : 8;
      exp_div = model_fast ? FAST_DIV : SLOW_DIV;
      exp_tx  = model_fast ? data : {24'b0, data[7:0]};
      exp_rx  = model_fast ? slave : {24'b0, slave[7:0]};
      sword   = slave;
      slen    = exp_n;
      sidx    = 0;
      miso    = sword[slen-1];
      rise_q.delete();
      mosi_q.delete();
      bus_write(1'b1, data, we);
      check("start_status", status, 32'h0);
      check("start_mosi_msb", {31'b0, mosi}, {31'b0, exp_tx[exp_n-1]});
   endtask

   task automatic finish_xfer(input string tag);
      int t;
      int bad;
      logic [31:0] obs;
      t = 0;
      while (status[0] !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      assert (status[0] === 1'b1) else begin
         failures++;
         $error("FAIL %s_timeout observed=%0d cycles expected ready", tag, t);
      end
      check({tag, "_length"}, cyc - we, 2 * exp_div * exp_n);
      check({tag, "_dout"}, dout, exp_rx);
      check({tag, "_rises"}, rise_q.size(), exp_n);
      bad = 0;
      obs = 32'b0;
      foreach (rise_q[i]) begin
         if (rise_q[i] != we + exp_div + 2 * exp_div * i) bad++;
         obs = {obs[30:0], mosi_q[i]};
      end
      check({tag, "_rise_times_bad"}, bad, 0);
      check({tag, "_mosi_bits"}, obs, exp_tx);
      check({tag, "_idle_lines"}, {30'b0, sclk, mosi}, 32'b01);
   endtask

   initial begin
      int e;
      logic [31:0] d, s, c;
      rst_n = 1'b0; data_en = 1'b0; ctrl_en = 1'b0; rd = 1'b0; wr = 1'b0;
      din = 32'b0; miso = 1'b0; model_fast = 1'b0; slen = 0; sidx = 0;
      repeat (3) @(negedge clk);
      check("rst_ss_n", {30'b0, ss_n}, 32'h3);
      check("rst_sclk", {31'b0, sclk}, 32'h0);
      check("rst_mosi", {31'b0, mosi}, 32'h1);
      check("rst_status", status, 32'h1);
      check("rst_dout", dout, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Slow transfer A5 out, 3C in, SD card selected.
      ctrl_write(32'h1);
      start_xfer(32'hA5, 32'h3C);
      finish_xfer("slow");
      check("slow_dout_literal", dout, 32'h0000003C);

      // Fast transfer DEADBEEF out, 12345678 in, back-to-back.
      ctrl_write(32'h5);
      start_xfer(32'hDEADBEEF, 32'h12345678);
      finish_xfer("fast");
      check("fast_dout_literal", dout, 32'h12345678);

      // A data write while busy is ignored.
      ctrl_write(32'h1);
      start_xfer(32'h81, 32'hC3);
      repeat (9) @(negedge clk);
      bus_write(1'b1, 32'hFF, e);
      check("busy_status", status, 32'h0);
      finish_xfer("busy");
      @(negedge clk);
      check("busy_single_xfer", status, 32'h1);

      // A mode change mid-transfer affects only the next transfer.
      start_xfer(32'h5A, 32'h99);
      repeat (20) @(negedge clk);
      ctrl_write(32'h4);
      finish_xfer("midmode_slow");
      start_xfer(32'hCAFEF00D, 32'h0BADBEEF);
      finish_xfer("midmode_fast");

      // Randomized transfers in both modes, issued back-to-back.
      for (int k = 0; k < 8; k++) begin
         c = $urandom_range(0, 7);
         ctrl_write(c);
         d = $urandom;
         s = $urandom;
         start_xfer(d, s);
         finish_xfer("rand");
      end

`ifdef SPI_HOST_IRQ_EN
      check("irq_set", {31'b0, irq}, 32'h1);
      data_en = 1'b1; rd = 1'b1;
      @(negedge clk);
      data_en = 1'b0; rd = 1'b0;
      check("irq_read_clear", {31'b0, irq}, 32'h0);
      ctrl_write(32'h4);
      start_xfer(32'h11223344, 32'h55667788);
      while (cyc < we + 2 * FAST_DIV * 32 - 1) @(negedge clk);
      data_en = 1'b1; rd = 1'b1;
      @(negedge clk);
      data_en = 1'b0; rd = 1'b0;
      check("irq_set_wins", {31'b0, irq}, 32'h1);
      finish_xfer("irq_xfer");
`endif

      // Reset in the middle of a slow transfer.
      ctrl_write(32'h2);
      start_xfer(32'hF0, 32'h0F);
      repeat (100) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ss_n", {30'b0, ss_n}, 32'h3);
      check("mid_rst_sclk", {31'b0, sclk}, 32'h0);
      check("mid_rst_mosi", {31'b0, mosi}, 32'h1);
      check("mid_rst_status", status, 32'h1);
      check("mid_rst_dout", dout, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_fast = 1'b0;
      @(negedge clk);

      // After reset the mode is slow again.
      start_xfer(32'h3C, 32'hA5);
      finish_xfer("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
